// File: rtl/riscv_cpu_pkg.sv
// Shared CPU constants and types: widths, funct3 encodings, writeback sources,
// memory-op codes, MEM stage FSM states and access-size helpers.
package riscv_cpu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [1:0] WDATA_ALU = 2'd0;
   localparam logic [1:0] WDATA_MEM = 2'd1;
   localparam logic [1:0] WDATA_PC  = 2'd2;

   localparam logic [1:0] MEM_OP_NONE  = 2'b00;
   localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
   localparam logic [1:0] MEM_OP_STORE = 2'b10;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_REQ,
      MS_WAIT_RVALID
   } mem_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } acc_size_t;

   // Unknown funct3 codes fall back to a full-word access.
   function automatic acc_size_t acc_size(input logic is_store, input logic [2:0] f3);
      acc_size_t sz;
      sz = SZ_WORD;
      if (is_store) begin
         if (f3 == SB)      sz = SZ_BYTE;
         else if (f3 == SH) sz = SZ_HALF;
      end else begin
         case (f3)
            LB, LBU: sz = SZ_BYTE;
            LH, LHU: sz = SZ_HALF;
            default: sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic [3:0] store_be(input acc_size_t sz, input logic [1:0] off);
      logic [3:0] be;
      case (sz)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the byte/half at the access offset and sign/zero extends.
// Latency: combinational. Backpressure: none.
// Half accesses use addr[1] only; word accesses always use lane 0.
module mem_load_align
   import riscv_cpu_pkg::*;
#(
   parameter int DATA_W = DATA_WIDTH
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        off,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] wdata
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   always_comb begin
      sel_b = rdata[{off, 3'b000} +: 8];
      sel_h = rdata[{off[1], 4'b0000} +: 16];
      case (funct3)
         LB:      wdata = {{(DATA_W-8){sel_b[7]}}, sel_b};
         LBU:     wdata = {{(DATA_W-8){1'b0}}, sel_b};
         LH:      wdata = {{(DATA_W-16){sel_h[15]}}, sel_h};
         LHU:     wdata = {{(DATA_W-16){1'b0}}, sel_h};
         default: wdata = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU ops pass to WB in 1 cycle; loads/stores run a req/gnt/rvalid handshake.
// Latency: 1 cycle for non-memory ops, grant+1 for stores, rvalid+1 for loads.
// Backpressure: stall_o (registered) is high whenever the FSM is out of IDLE. MEM_STAGE_MISALIGN_CHECK_EN enables misalignment trapping.
module mem_stage
   import riscv_cpu_pkg::*;
#(
   parameter int DATA_W = DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ex_valid_i,
   input  logic [DATA_W-1:0]     ex_alu_result_i,
   input  logic [1:0]            ex_mem_op_i,
   input  logic [2:0]            ex_funct3_i,
   input  logic [DATA_W-1:0]     ex_mem_wdata_i,
   input  logic                  ex_reg_we_i,
   input  logic [ADDR_WIDTH-1:0] ex_dest_reg_i,
   output logic                  stall_o,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   output logic [DATA_W-1:0]     data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [DATA_W-1:0]     data_wdata_o,
   input  logic                  data_rvalid_i,
   input  logic [DATA_W-1:0]     data_rdata_i,
   output logic                  wb_valid_o,
   output logic                  wb_reg_we_o,
   output logic [ADDR_WIDTH-1:0] wb_dest_reg_o,
   output logic [DATA_W-1:0]     wb_wdata_o,
   output logic                  misaligned_o
);

   mem_state_t            state;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic                  reg_we_q;
   logic [ADDR_WIDTH-1:0] dest_q;

   logic                  accept;
   logic                  is_load;
   logic                  is_store;
   logic [1:0]            off;
   acc_size_t             sz;
   logic                  mis_acc;
   logic [3:0]            st_be;
   logic [DATA_W-1:0]     st_wdata;
   logic [DATA_W-1:0]     load_wdata;
   logic [1:0]            wb_sel;
   logic [DATA_W-1:0]     wb_data_d;

   assign accept   = ex_valid_i & ~stall_o;
   assign is_load  = (ex_mem_op_i == MEM_OP_LOAD);
   assign is_store = (ex_mem_op_i == MEM_OP_STORE);
   assign off      = ex_alu_result_i[1:0];
   assign sz       = acc_size(is_store, ex_funct3_i);
   assign st_be    = store_be(sz, off);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   assign mis_acc = (is_load | is_store) &
                    (((sz == SZ_HALF) & off[0]) | ((sz == SZ_WORD) & (off != 2'b00)));
`else
   assign mis_acc = 1'b0;
`endif

   always_comb begin
      case (sz)
         SZ_BYTE: st_wdata = {(DATA_W/8){ex_mem_wdata_i[7:0]}};
         SZ_HALF: st_wdata = {(DATA_W/16){ex_mem_wdata_i[15:0]}};
         default: st_wdata = ex_mem_wdata_i;
      endcase
   end

   always_comb begin
      wb_sel    = (state == MS_WAIT_RVALID) ? WDATA_MEM : WDATA_ALU;
      wb_data_d = (wb_sel == WDATA_MEM) ? load_wdata : ex_alu_result_i;
   end

   mem_load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .rdata  (data_rdata_i),
      .off    (off_q),
      .funct3 (funct3_q),
      .wdata  (load_wdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= MS_IDLE;
         stall_o       <= 1'b0;
         data_req_o    <= 1'b0;
         data_addr_o   <= '0;
         data_we_o     <= 1'b0;
         data_be_o     <= '0;
         data_wdata_o  <= '0;
         wb_valid_o    <= 1'b0;
         wb_reg_we_o   <= 1'b0;
         wb_dest_reg_o <= '0;
         wb_wdata_o    <= '0;
         funct3_q      <= '0;
         off_q         <= '0;
         reg_we_q      <= 1'b0;
         dest_q        <= '0;
      end else begin
         wb_valid_o  <= 1'b0;
         wb_reg_we_o <= 1'b0;
         case (state)
            MS_IDLE: begin
               if (accept) begin
                  if (!(is_load || is_store)) begin
                     wb_valid_o    <= 1'b1;
                     wb_reg_we_o   <= ex_reg_we_i;
                     wb_dest_reg_o <= ex_dest_reg_i;
                     wb_wdata_o    <= wb_data_d;
                  end else if (mis_acc) begin
                     wb_valid_o    <= 1'b1;
                     wb_dest_reg_o <= ex_dest_reg_i;
                  end else begin
                     state        <= MS_REQ;
                     stall_o      <= 1'b1;
                     data_req_o   <= 1'b1;
                     data_addr_o  <= {ex_alu_result_i[DATA_W-1:2], 2'b00};
                     data_we_o    <= is_store;
                     data_be_o    <= st_be;
                     data_wdata_o <= st_wdata;
                     funct3_q     <= ex_funct3_i;
                     off_q        <= off;
                     reg_we_q     <= ex_reg_we_i;
                     dest_q       <= ex_dest_reg_i;
                  end
               end
            end
            MS_REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  if (data_we_o) begin
                     state         <= MS_IDLE;
                     stall_o       <= 1'b0;
                     wb_valid_o    <= 1'b1;
                     wb_dest_reg_o <= dest_q;
                  end else begin
                     state <= MS_WAIT_RVALID;
                  end
               end
            end
            MS_WAIT_RVALID: begin
               if (data_rvalid_i) begin
                  state         <= MS_IDLE;
                  stall_o       <= 1'b0;
                  wb_valid_o    <= 1'b1;
                  wb_reg_we_o   <= reg_we_q;
                  wb_dest_reg_o <= dest_q;
                  wb_wdata_o    <= wb_data_d;
               end
            end
            default: begin
               state      <= MS_IDLE;
               stall_o    <= 1'b0;
               data_req_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   logic misaligned_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) misaligned_q <= 1'b0;
      else       misaligned_q <= accept & mis_acc;
   end

   assign misaligned_o = misaligned_q;
`else
   assign misaligned_o = 1'b0;
`endif

endmodule
